// File: rtl/thermo_encoder_pipe.sv
// Pipelined thermometer-to-binary encoder for the flash ADC back end.
// Capture, bubble correction, priority encode and windowed averaging feed a registered output stage.
module thermo_encoder_pipe #(
    parameter int N_BITS     = 8,
    parameter int BUBBLE_FIX = 1,
    parameter int AVG_LOG2   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sync_clr,
    input  logic                 in_valid,
    input  logic [2**N_BITS-1:0] therm_in,
    output logic                 out_valid,
    output logic [N_BITS-1:0]    code_out,
    output logic                 ovr,
    output logic                 und
);

    localparam int TW = 2**N_BITS;
    localparam int AW = N_BITS + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((2**AVG_LOG2) - 1);

    logic [TW-1:0]     r_therm;
    logic              r_v1;
    logic [TW-1:0]     w_corr;
    logic [TW-1:0]     r_corr;
    logic              r_ovr2;
    logic              r_und2;
    logic              r_v2;
    logic [N_BITS-1:0] w_code;
    logic [N_BITS-1:0] r_code;
    logic              r_ovr3;
    logic              r_und3;
    logic              r_v3;
    logic [AW-1:0]     r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_stickyOvr;
    logic              r_stickyUnd;
    logic [AW-1:0]     w_sum;
    logic              w_last;
    logic              w_ovrAll;
    logic              w_undAll;
    logic              r_resValid;
    logic [N_BITS-1:0] r_resCode;
    logic              r_resOvr;
    logic              r_resUnd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_therm <= '0;
            r_v1    <= 1'b0;
        end else if (sync_clr) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_therm <= therm_in;
            end
        end
    end

    // Edges behave as if a tripped comparator sits below bit 0 and an idle one above the top bit.
    generate
        if (BUBBLE_FIX != 0) begin : g_fix
            logic [TW+1:0] w_ext;
            assign w_ext = {1'b0, r_therm, 1'b1};
            for (genvar gi = 0; gi < TW; gi++) begin : g_maj
                assign w_corr[gi] = (w_ext[gi] & w_ext[gi+1]) |
                                    (w_ext[gi] & w_ext[gi+2]) |
                                    (w_ext[gi+1] & w_ext[gi+2]);
            end
        end else begin : g_raw
            assign w_corr = r_therm;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_corr <= '0;
            r_ovr2 <= 1'b0;
            r_und2 <= 1'b0;
            r_v2   <= 1'b0;
        end else if (sync_clr) begin
            r_v2 <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_corr <= w_corr;
                r_ovr2 <= w_corr[TW-1];
                r_und2 <= (w_corr == '0);
            end
        end
    end

    // Highest set bit wins, so residual non-monotonic patterns still resolve upward.
    always_comb begin
        w_code = '0;
        for (int i = 0; i < TW; i++) begin
            if (r_corr[i]) begin
                w_code = N_BITS'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code <= '0;
            r_ovr3 <= 1'b0;
            r_und3 <= 1'b0;
            r_v3   <= 1'b0;
        end else if (sync_clr) begin
            r_v3 <= 1'b0;
        end else begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_code <= w_code;
                r_ovr3 <= r_ovr2;
                r_und3 <= r_und2;
            end
        end
    end

    // The accumulator is wide enough for a full window of maximum codes, so it never wraps.
    assign w_sum    = r_acc + AW'(r_code);
    assign w_last   = (r_cnt == LAST_CNT);
    assign w_ovrAll = r_stickyOvr | r_ovr3;
    assign w_undAll = r_stickyUnd | r_und3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_stickyOvr <= 1'b0;
            r_stickyUnd <= 1'b0;
            r_resValid  <= 1'b0;
            r_resCode   <= '0;
            r_resOvr    <= 1'b0;
            r_resUnd    <= 1'b0;
        end else if (sync_clr) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_stickyOvr <= 1'b0;
            r_stickyUnd <= 1'b0;
            r_resValid  <= 1'b0;
        end else begin
            r_resValid <= 1'b0;
            if (r_v3) begin
                if (w_last) begin
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_stickyOvr <= 1'b0;
                    r_stickyUnd <= 1'b0;
                    r_resValid  <= 1'b1;
                    r_resCode   <= w_sum[AW-1:AVG_LOG2];
                    r_resOvr    <= w_ovrAll;
                    r_resUnd    <= w_undAll;
                end else begin
                    r_acc       <= w_sum;
                    r_cnt       <= r_cnt + CW'(1);
                    r_stickyOvr <= w_ovrAll;
                    r_stickyUnd <= w_undAll;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            code_out  <= '0;
            ovr       <= 1'b0;
            und       <= 1'b0;
        end else if (sync_clr) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_resValid;
            if (r_resValid) begin
                code_out <= r_resCode;
                ovr      <= r_resOvr;
                und      <= r_resUnd;
            end
        end
    end

endmodule

// File: tb/tb_thermo_encoder_pipe.sv
// Bench for thermo_encoder_pipe: three instances (default, no bubble fix, 4-sample averaging)
// share stimulus; expected results are queued at drive time and checked when out_valid pulses.
module tb_thermo_encoder_pipe;

    localparam int NB = 8;
    localparam int TW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          syncClr;
    logic [TW-1:0] thermIn;
    logic          validA, validB, validC;
    logic          outValidA, outValidB, outValidC;
    logic [NB-1:0] codeA, codeB, codeC;
    logic          ovrA, ovrB, ovrC;
    logic          undA, undB, undC;

    typedef struct {
        logic [NB-1:0] code;
        logic          ovr;
        logic          und;
        int            due;
    } expT;

    typedef struct {
        logic [TW-1:0] therm;
        logic [NB-1:0] codeA;
        logic          ovrA;
        logic          undA;
        logic [NB-1:0] codeB;
        logic          ovrB;
        logic          undB;
    } vecT;

    expT qA[$];
    expT qB[$];
    expT qC[$];
    expT eMon;
    vecT vecs[10];
    int  checks = 0;
    int  failures = 0;
    int  cycleCount = 0;
    int  lastDue = 0;

    thermo_encoder_pipe #(.N_BITS(NB), .BUBBLE_FIX(1), .AVG_LOG2(0)) dutA (
        .clk(clk), .rst(rst), .sync_clr(syncClr), .in_valid(validA), .therm_in(thermIn),
        .out_valid(outValidA), .code_out(codeA), .ovr(ovrA), .und(undA));

    thermo_encoder_pipe #(.N_BITS(NB), .BUBBLE_FIX(0), .AVG_LOG2(0)) dutB (
        .clk(clk), .rst(rst), .sync_clr(syncClr), .in_valid(validB), .therm_in(thermIn),
        .out_valid(outValidB), .code_out(codeB), .ovr(ovrB), .und(undB));

    thermo_encoder_pipe #(.N_BITS(NB), .BUBBLE_FIX(1), .AVG_LOG2(2)) dutC (
        .clk(clk), .rst(rst), .sync_clr(syncClr), .in_valid(validC), .therm_in(thermIn),
        .out_valid(outValidC), .code_out(codeC), .ovr(ovrC), .und(undC));

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    function automatic logic [TW-1:0] thermoOnes(input int k);
        logic [TW-1:0] r;
        r = '0;
        for (int i = 0; i <= k && i < TW; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input expT e, input logic [NB-1:0] code,
                               input logic o, input logic u);
        checkValue({name, ".code"}, 32'(code), 32'(e.code));
        checkValue({name, ".ovr"}, 32'(o), 32'(e.ovr));
        checkValue({name, ".und"}, 32'(u), 32'(e.und));
        checkValue({name, ".cycle"}, 32'(cycleCount), 32'(e.due));
    endtask

    task automatic unexpected(input string name, input logic [NB-1:0] code);
        checks++;
        failures++;
        $display("[TB] FAIL %s.unexpected actual=out_valid code %0d required=no output", name, code);
    endtask

    // Outputs are sampled on the falling edge, well clear of the rising edge the DUT uses.
    always @(negedge clk) begin
        if (outValidA === 1'b1) begin
            if (qA.size() == 0) unexpected("A", codeA);
            else begin
                eMon = qA.pop_front();
                checkOutput("A", eMon, codeA, ovrA, undA);
            end
        end
        if (outValidB === 1'b1) begin
            if (qB.size() == 0) unexpected("B", codeB);
            else begin
                eMon = qB.pop_front();
                checkOutput("B", eMon, codeB, ovrB, undB);
            end
        end
        if (outValidC === 1'b1) begin
            if (qC.size() == 0) unexpected("C", codeC);
            else begin
                eMon = qC.pop_front();
                checkOutput("C", eMon, codeC, ovrC, undC);
            end
        end
    end

    task automatic applyStimulus(input logic [TW-1:0] t, input logic [2:0] mask, input logic clr);
        @(negedge clk);
        thermIn = t;
        validA  = mask[0];
        validB  = mask[1];
        validC  = mask[2];
        syncClr = clr;
        lastDue = cycleCount + 5;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            validA  = 1'b0;
            validB  = 1'b0;
            validC  = 1'b0;
            syncClr = 1'b0;
        end
    endtask

    task automatic pushExpect(input int which, input int code, input logic o, input logic u);
        expT e;
        e.code = NB'(code);
        e.ovr  = o;
        e.und  = u;
        e.due  = lastDue;
        case (which)
            0:       qA.push_back(e);
            1:       qB.push_back(e);
            default: qC.push_back(e);
        endcase
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        idle(1);
        while ((qA.size() + qB.size() + qC.size()) != 0 && budget < 60) begin
            @(negedge clk);
            budget++;
        end
        if ((qA.size() + qB.size() + qC.size()) != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain.timeout actual=%0d pending required=0 pending",
                     qA.size() + qB.size() + qC.size());
            qA.delete();
            qB.delete();
            qC.delete();
        end
        idle(2);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=no finish required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [TW-1:0] t;
        rst     = 1'b1;
        syncClr = 1'b0;
        validA  = 1'b0;
        validB  = 1'b0;
        validC  = 1'b0;
        thermIn = '0;

        vecs[0] = '{thermoOnes(99),  8'd99,  1'b0, 1'b0, 8'd99,  1'b0, 1'b0};
        vecs[1] = '{thermoOnes(9),   8'd9,   1'b0, 1'b0, 8'd9,   1'b0, 1'b0};
        vecs[2] = '{thermoOnes(200), 8'd200, 1'b0, 1'b0, 8'd200, 1'b0, 1'b0};
        vecs[3] = '{thermoOnes(255), 8'd255, 1'b1, 1'b0, 8'd255, 1'b1, 1'b0};
        vecs[4] = '{'0,              8'd0,   1'b0, 1'b1, 8'd0,   1'b0, 1'b1};
        t = thermoOnes(49);
        t[47] = 1'b0;
        t[52] = 1'b1;
        vecs[5] = '{t,               8'd49,  1'b0, 1'b0, 8'd52,  1'b0, 1'b0};
        t = '0;
        t[100] = 1'b1;
        vecs[6] = '{t,               8'd0,   1'b0, 1'b1, 8'd100, 1'b0, 1'b0};
        t = '0;
        t[255] = 1'b1;
        vecs[7] = '{t,               8'd0,   1'b0, 1'b1, 8'd255, 1'b1, 1'b0};
        t = thermoOnes(255);
        t[254] = 1'b0;
        vecs[8] = '{t,               8'd254, 1'b0, 1'b0, 8'd255, 1'b1, 1'b0};
        t = thermoOnes(9);
        t[20] = 1'b1;
        t[21] = 1'b1;
        t[22] = 1'b1;
        vecs[9] = '{t,               8'd22,  1'b0, 1'b0, 8'd22,  1'b0, 1'b0};

        #2;
        checkValue("reset.validA", 32'(outValidA), 0);
        checkValue("reset.validB", 32'(outValidB), 0);
        checkValue("reset.validC", 32'(outValidC), 0);
        checkValue("reset.codeA", 32'(codeA), 0);
        checkValue("reset.ovrA", 32'(ovrA), 0);
        checkValue("reset.undA", 32'(undA), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] table vectors, back to back on A and B");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].therm, 3'b011, 1'b0);
            pushExpect(0, int'(vecs[i].codeA), vecs[i].ovrA, vecs[i].undA);
            pushExpect(1, int'(vecs[i].codeB), vecs[i].ovrB, vecs[i].undB);
        end
        drain();
        checkValue("hold.validA", 32'(outValidA), 0);
        checkValue("hold.codeA", 32'(codeA), 22);
        checkValue("hold.codeB", 32'(codeB), 22);

        $display("[TB] averaging windows on C");
        applyStimulus(thermoOnes(10), 3'b100, 1'b0);
        applyStimulus(thermoOnes(11), 3'b100, 1'b0);
        idle(1);
        applyStimulus(thermoOnes(12), 3'b100, 1'b0);
        applyStimulus(thermoOnes(13), 3'b100, 1'b0);
        pushExpect(2, 11, 1'b0, 1'b0);
        drain();
        applyStimulus('0, 3'b100, 1'b0);
        applyStimulus(thermoOnes(255), 3'b100, 1'b0);
        applyStimulus(thermoOnes(255), 3'b100, 1'b0);
        applyStimulus(thermoOnes(255), 3'b100, 1'b0);
        pushExpect(2, 191, 1'b1, 1'b1);
        drain();

        $display("[TB] flush mid-window on C");
        applyStimulus(thermoOnes(50), 3'b100, 1'b0);
        applyStimulus(thermoOnes(50), 3'b100, 1'b0);
        applyStimulus(thermoOnes(50), 3'b100, 1'b1);
        idle(8);
        checkValue("flush.validC", 32'(outValidC), 0);
        checkValue("flush.codeC", 32'(codeC), 191);
        checkValue("flush.ovrC", 32'(ovrC), 1);
        checkValue("flush.undC", 32'(undC), 1);
        for (int i = 0; i < 4; i++) applyStimulus(thermoOnes(20), 3'b100, 1'b0);
        pushExpect(2, 20, 1'b0, 1'b0);
        drain();

        $display("[TB] reset with pipelines and window partly filled");
        for (int i = 0; i < 3; i++) applyStimulus(thermoOnes(60), 3'b100, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(thermoOnes(60), 3'b111, 1'b0);
        @(posedge clk);
        #2;
        rst    = 1'b1;
        validA = 1'b0;
        validB = 1'b0;
        validC = 1'b0;
        #1;
        checkValue("midrst.validA", 32'(outValidA), 0);
        checkValue("midrst.codeA", 32'(codeA), 0);
        checkValue("midrst.codeB", 32'(codeB), 0);
        checkValue("midrst.codeC", 32'(codeC), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(thermoOnes(33), 3'b101, 1'b0);
        pushExpect(0, 33, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(thermoOnes(7), 3'b100, 1'b0);
        pushExpect(2, 13, 1'b0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
